// File: rtl/cr_su_req_arb_if.sv
// Handshake bundle between the requesters, the arbiter and the downstream
// schedule-update consumer (cr_su_core input side).
`timescale 1ns/1ps
interface cr_su_req_arb_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic                    su_valid;
    logic [DATA_W-1:0]       su_data;
    logic                    su_ready;
    logic [IDW-1:0]          grant_id;

    modport slave (
        input  req_valid, req_data, su_ready,
        output req_ack, su_valid, su_data, grant_id
    );

    modport master (
        output req_valid, req_data, su_ready,
        input  req_ack, su_valid, su_data, grant_id
    );
endinterface

// File: rtl/cr_su_req_arb.sv
// Round-robin burst arbiter feeding the single schedule-update input of
// cr_su_core, with registered output slot and sticky per-requester starvation flags.
`timescale 1ns/1ps
module cr_su_req_arb #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    cr_su_req_arb_if.slave     bus,
    output logic [N_REQ-1:0]   starve_err,
    input  logic [N_REQ-1:0]   starve_clr,
    output logic               busy
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WCW = $clog2(STARVE_LIMIT + 1);
    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
    localparam logic [WCW-1:0] WAIT_MAX   = WCW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_r;
    logic [IDW-1:0]     cur_r;
    logic [IDW-1:0]     ptr_r;
    logic [BCW-1:0]     burst_cnt_r;
    logic               su_valid_r;
    logic [DATA_W-1:0]  su_data_r;
    logic [IDW-1:0]     grant_id_r;
    logic [WCW-1:0]     wait_cnt_r [N_REQ];
    logic [N_REQ-1:0]   starve_err_r;

    logic [IDW-1:0]     base_s;
    logic [IDW-1:0]     winner_s;
    logic               hold_keep_s;
    logic               win_vld_s;
    logic               out_free_s;
    logic               cap_s;
    logic [N_REQ-1:0]   ack_s;

    // Winner selection: keep the current holder, else scan round-robin after the base.
    // A holder that just dropped valid becomes the scan base so it ends up lowest priority.
    always_comb begin
        logic found;
        logic hit;
        int   idx;
        found       = 1'b0;
        hit         = 1'b0;
        idx         = 0;
        hold_keep_s = (state_r == HOLD) && bus.req_valid[cur_r];
        base_s      = (state_r == HOLD) ? cur_r : ptr_r;
        winner_s    = cur_r;
        for (int k = 1; k <= N_REQ; k++) begin
            idx      = int'(base_s) + k;
            idx      = (idx >= N_REQ) ? (idx - N_REQ) : idx;
            hit      = !hold_keep_s && !found && bus.req_valid[IDW'(idx)];
            winner_s = hit ? IDW'(idx) : winner_s;
            found    = found | hit;
        end
        win_vld_s  = |bus.req_valid;
        out_free_s = !su_valid_r || bus.su_ready;
        cap_s      = rst_n && en && out_free_s && win_vld_s;
    end

    // One-hot accept toward the winning requester, only when the beat is captured.
    always_comb begin
        ack_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack_s[i] = cap_s && (winner_s == IDW'(i));
        end
    end

    assign bus.req_ack  = ack_s;
    assign bus.su_valid = su_valid_r;
    assign bus.su_data  = su_data_r;
    assign bus.grant_id = grant_id_r;
    assign starve_err   = starve_err_r;
    assign busy         = su_valid_r || (|bus.req_valid);

    // Output slot: load on capture, empty once downstream accepts without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            su_valid_r <= 1'b0;
            su_data_r  <= '0;
            grant_id_r <= '0;
        end else if (cap_s) begin
            su_valid_r <= 1'b1;
            su_data_r  <= bus.req_data[winner_s*DATA_W +: DATA_W];
            grant_id_r <= winner_s;
        end else if (bus.su_ready) begin
            su_valid_r <= 1'b0;
        end else begin
            su_valid_r <= su_valid_r;
        end
    end

    // Burst state machine: tracks the holder, its beat count and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cur_r       <= '0;
            ptr_r       <= IDW'(N_REQ - 1);
            burst_cnt_r <= '0;
        end else if (!en) begin
            state_r     <= IDLE;
            burst_cnt_r <= '0;
        end else if (cap_s && hold_keep_s) begin
            if (burst_cnt_r >= BURST_LAST) begin
                state_r     <= IDLE;
                ptr_r       <= cur_r;
                burst_cnt_r <= '0;
            end else begin
                burst_cnt_r <= burst_cnt_r + BCW'(1);
            end
        end else if (cap_s) begin
            if (MAX_BURST == 1) begin
                state_r     <= IDLE;
                ptr_r       <= winner_s;
                burst_cnt_r <= '0;
            end else begin
                state_r     <= HOLD;
                cur_r       <= winner_s;
                ptr_r       <= (state_r == HOLD) ? cur_r : ptr_r;
                burst_cnt_r <= BCW'(1);
            end
        end else if ((state_r == HOLD) && !bus.req_valid[cur_r]) begin
            state_r     <= IDLE;
            ptr_r       <= cur_r;
            burst_cnt_r <= '0;
        end else begin
            state_r <= state_r;
        end
    end

    // Starvation tracking: saturating wait counters and sticky flags (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_err_r <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!bus.req_valid[i] || ack_s[i]) begin
                    wait_cnt_r[i] <= '0;
                end else if (wait_cnt_r[i] != WAIT_MAX) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + WCW'(1);
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
                if (wait_cnt_r[i] == WAIT_MAX) begin
                    starve_err_r[i] <= 1'b1;
                end else if (starve_clr[i]) begin
                    starve_err_r[i] <= 1'b0;
                end else begin
                    starve_err_r[i] <= starve_err_r[i];
                end
            end
        end
    end
endmodule
